// File: rtl/sys_time_rd_cpl_pkg.sv
// Shared TLP encodings, BAR0 register offsets and types for the system-time read completer.
// The format/type codes and offsets are common to the BAR0 write path.
package sys_time_rd_cpl_pkg;

   localparam logic [6:0]  MEM_RD32_FMT_TYPE = 7'b000_0000;
   localparam logic [6:0]  MEM_RD64_FMT_TYPE = 7'b010_0000;
   localparam logic [6:0]  CPLD_FMT_TYPE     = 7'b100_1010;
   localparam logic [2:0]  CPL_STATUS_SC     = 3'b000;
   localparam logic [9:0]  CPL_LEN_DW        = 10'd1;
   localparam logic [11:0] CPL_BYTE_COUNT    = 12'd4;

   localparam logic [3:0]  BAR0_NSECS_OFF    = 4'h8;
   localparam logic [3:0]  BAR0_SECS_OFF     = 4'h9;
   localparam logic [3:0]  BAR0_TSEN_OFF     = 4'hA;

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_HDR   = 5'b00010,
      S_REQ   = 5'b00100,
      S_BEAT0 = 5'b01000,
      S_BEAT1 = 5'b10000
   } cpl_state_e;

   typedef enum logic {
      SNOOP_IDLE,
      SNOOP_ADDR
   } snoop_state_e;

   typedef struct packed {
      logic        is64;
      logic [2:0]  tc;
      logic [1:0]  attr;
      logic [15:0] req_id;
      logic [7:0]  tag;
   } rd_req_t;

   function automatic logic is_mem_rd(input logic [6:0] fmt_type);
      return (fmt_type == MEM_RD32_FMT_TYPE) || (fmt_type == MEM_RD64_FMT_TYPE);
   endfunction

   // Address beat: a 3DW header carries the address in DW2 (upper half), a 4DW header in DW3.
   function automatic logic [6:2] rd_dw_addr(input logic is64, input logic [63:0] rd);
      return is64 ? rd[6:2] : rd[38:34];
   endfunction

   // Payload byte order matches what the BAR0 write path expects.
   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

endpackage

// File: rtl/sys_time_rd_cpl_hdr_build.sv
// Builds the two 64-bit beats of a 1-DW successful CplD from captured request fields.
// Pure combinational; intended for reuse by other BAR0 read responders.
module cpl_hdr_build
   import sys_time_rd_cpl_pkg::*;
(
   input  logic [2:0]  tc,
   input  logic [1:0]  attr,
   input  logic [15:0] completer_id,
   input  logic [15:0] req_id,
   input  logic [7:0]  tag,
   input  logic [6:2]  lower_addr,
   input  logic [31:0] data,
   output logic [63:0] beat0,
   output logic [63:0] beat1
);

   // Only whole-DW single reads are served, so byte count and lower_addr[1:0] are fixed.
   assign beat0 = {1'b0, CPLD_FMT_TYPE, 1'b0, tc, 4'b0000, 2'b00, attr, 2'b00, CPL_LEN_DW,
                   completer_id, CPL_STATUS_SC, 1'b0, CPL_BYTE_COUNT};

   assign beat1 = {req_id, tag, 1'b0, lower_addr, 2'b00, bswap32(data)};

endmodule

// File: rtl/sys_time_rd_cpl.sv
// Snoops TRN RX for BAR0 reads of the system-time registers and answers with a 1-DW CplD on TRN TX.
// A separate snooper flags reads that arrive while a completion is still pending.
module sys_time_rd_cpl
   import sys_time_rd_cpl_pkg::*;
#(
   parameter logic [3:0] NSECS_OFF = BAR0_NSECS_OFF,
   parameter logic [3:0] SECS_OFF  = BAR0_SECS_OFF,
   parameter logic [3:0] TSEN_OFF  = BAR0_TSEN_OFF
) (
   input  logic        trn_clk,
   input  logic        reset,
   input  logic [63:0] trn_rd,
   input  logic        trn_rsof_n,
   input  logic        trn_reof_n,
   input  logic        trn_rsrc_rdy_n,
   input  logic        trn_rdst_rdy_n,
   input  logic [6:0]  trn_rbar_hit_n,
   output logic [63:0] trn_td,
   output logic [7:0]  trn_trem_n,
   output logic        trn_tsof_n,
   output logic        trn_teof_n,
   output logic        trn_tsrc_rdy_n,
   input  logic        trn_tdst_rdy_n,
   output logic        tx_req,
   input  logic        tx_grant,
   input  logic [15:0] cfg_completer_id,
   input  logic [31:0] sys_nsecs,
   input  logic [31:0] sys_secs,
   input  logic        rx_timestamp_en,
   output logic        rd_overrun
);

   cpl_state_e   state, state_n;
   snoop_state_e snoop, snoop_n;

   rd_req_t      req_q;
   logic [6:2]   lower_addr_q;
   logic [31:0]  data_q;

   logic         rx_acc, tx_acc, rx_sof_rd, rx_is64, busy;
   logic [6:2]   hdr_dw, snoop_dw;
   logic         hdr_hit, snoop_hit;
   logic [31:0]  rd_val;
   logic         capture_req, capture_data;
   logic         snoop_is64, snoop_drop, snoop_arm, set_overrun;
   logic [63:0]  beat0, beat1;
   logic         unused_rx;

   function automatic logic off_hit(input logic [3:0] off);
      return (off == NSECS_OFF) || (off == SECS_OFF) || (off == TSEN_OFF);
   endfunction

   assign rx_acc    = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
   assign tx_acc    = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
   assign rx_sof_rd = rx_acc && !trn_rsof_n && !trn_rbar_hit_n[0] && is_mem_rd(trn_rd[62:56]);
   assign rx_is64   = (trn_rd[62:56] == MEM_RD64_FMT_TYPE);
   assign busy      = !((state == S_IDLE) || (state == S_HDR));

   assign hdr_dw    = rd_dw_addr(req_q.is64, trn_rd);
   assign hdr_hit   = off_hit(hdr_dw[5:2]);
   assign snoop_dw  = rd_dw_addr(snoop_is64, trn_rd);
   assign snoop_hit = off_hit(snoop_dw[5:2]);

   // Frame markers and the other BARs play no part in decoding a 1-DW read.
   assign unused_rx = ^{trn_reof_n, trn_rd, trn_rbar_hit_n[6:1]};

   always_comb begin
      rd_val = sys_nsecs;
      if (hdr_dw[5:2] == SECS_OFF)      rd_val = sys_secs;
      else if (hdr_dw[5:2] == TSEN_OFF) rd_val = {31'b0, rx_timestamp_en};
   end

   cpl_hdr_build u_hdr (
      .tc           (req_q.tc),
      .attr         (req_q.attr),
      .completer_id (cfg_completer_id),
      .req_id       (req_q.req_id),
      .tag          (req_q.tag),
      .lower_addr   (lower_addr_q),
      .data         (data_q),
      .beat0        (beat0),
      .beat1        (beat1)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge trn_clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // NOTE: captured request fields are qualified by the FSM before use, so they carry no reset.
   always_ff @(posedge trn_clk) begin
      if (capture_req) begin
         req_q.is64   <= rx_is64;
         req_q.tc     <= trn_rd[54:52];
         req_q.attr   <= trn_rd[45:44];
         req_q.req_id <= trn_rd[31:16];
         req_q.tag    <= trn_rd[15:8];
      end
      if (capture_data) begin
         lower_addr_q <= hdr_dw;
         data_q       <= rd_val;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_n        = state;
      capture_req    = 1'b0;
      capture_data   = 1'b0;
      tx_req         = 1'b0;
      trn_tsof_n     = 1'b1;
      trn_teof_n     = 1'b1;
      trn_tsrc_rdy_n = 1'b1;
      trn_trem_n     = 8'hFF;
      trn_td         = '0;
      unique case (state)
         S_IDLE: begin
            if (rx_sof_rd) begin
               capture_req = 1'b1;
               state_n     = S_HDR;
            end
         end
         S_HDR: begin
            if (rx_acc) begin
               if (hdr_hit) begin
                  capture_data = 1'b1;
                  state_n      = S_REQ;
               end else begin
                  state_n      = S_IDLE;
               end
            end
         end
         S_REQ: begin
            tx_req = 1'b1;
            if (tx_grant) state_n = S_BEAT0;
         end
         S_BEAT0: begin
            tx_req         = 1'b1;
            trn_tsof_n     = 1'b0;
            trn_tsrc_rdy_n = 1'b0;
            trn_trem_n     = 8'h00;
            trn_td         = beat0;
            if (tx_acc) state_n = S_BEAT1;
         end
         S_BEAT1: begin
            tx_req         = 1'b1;
            trn_teof_n     = 1'b0;
            trn_tsrc_rdy_n = 1'b0;
            trn_trem_n     = 8'h00;
            trn_td         = beat1;
            if (tx_acc) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Independent snooper: notes whether the main FSM was busy at SOF, judges the offset one beat later.
   always_comb begin
      snoop_n     = snoop;
      snoop_arm   = 1'b0;
      set_overrun = 1'b0;
      unique case (snoop)
         SNOOP_IDLE: begin
            if (rx_sof_rd) begin
               snoop_arm = 1'b1;
               snoop_n   = SNOOP_ADDR;
            end
         end
         SNOOP_ADDR: begin
            if (rx_acc) begin
               set_overrun = snoop_drop && snoop_hit;
               snoop_n     = SNOOP_IDLE;
            end
         end
         default: snoop_n = SNOOP_IDLE;
      endcase
   end

   always_ff @(posedge trn_clk) begin
      if (reset) begin
         snoop      <= SNOOP_IDLE;
         snoop_is64 <= 1'b0;
         snoop_drop <= 1'b0;
         rd_overrun <= 1'b0;
      end else begin
         snoop <= snoop_n;
         if (snoop_arm) begin
            snoop_is64 <= rx_is64;
            snoop_drop <= busy;
         end
         if (set_overrun) rd_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sys_time_rd_cpl.sv
// Directed plus randomized bench for sys_time_rd_cpl; expected completions come from TLP field arithmetic.
// A bench-side arbiter grants TX after a programmable delay and a monitor logs accepted TX beats.
module tb_sys_time_rd_cpl;

   logic        trn_clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] trn_rd = '0;
   logic        trn_rsof_n = 1'b1;
   logic        trn_reof_n = 1'b1;
   logic        trn_rsrc_rdy_n = 1'b1;
   logic        trn_rdst_rdy_n = 1'b0;
   logic [6:0]  trn_rbar_hit_n = 7'h7F;
   logic [63:0] trn_td;
   logic [7:0]  trn_trem_n;
   logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
   logic        trn_tdst_rdy_n;
   logic        tx_req;
   logic        tx_grant;
   logic [15:0] cfg_completer_id = 16'h0A18;
   logic [31:0] sys_nsecs = '0;
   logic [31:0] sys_secs = '0;
   logic        rx_timestamp_en = 1'b0;
   logic        rd_overrun;

   int total = 0;
   int bad = 0;
   int grant_delay = 0;
   int stall_mode = 0;   // 0 always ready, 1 random, 2 toggle, 3 hold off
   int stall_cycles = 0;
   int stall_bad = 0;
   int req_cycles = 0;
   logic [65:0] acc_q[$];  // {sof_n, eof_n, td} of each accepted TX beat

   sys_time_rd_cpl dut (
      .trn_clk          (trn_clk),
      .reset            (reset),
      .trn_rd           (trn_rd),
      .trn_rsof_n       (trn_rsof_n),
      .trn_reof_n       (trn_reof_n),
      .trn_rsrc_rdy_n   (trn_rsrc_rdy_n),
      .trn_rdst_rdy_n   (trn_rdst_rdy_n),
      .trn_rbar_hit_n   (trn_rbar_hit_n),
      .trn_td           (trn_td),
      .trn_trem_n       (trn_trem_n),
      .trn_tsof_n       (trn_tsof_n),
      .trn_teof_n       (trn_teof_n),
      .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
      .trn_tdst_rdy_n   (trn_tdst_rdy_n),
      .tx_req           (tx_req),
      .tx_grant         (tx_grant),
      .cfg_completer_id (cfg_completer_id),
      .sys_nsecs        (sys_nsecs),
      .sys_secs         (sys_secs),
      .rx_timestamp_en  (rx_timestamp_en),
      .rd_overrun       (rd_overrun)
   );

   always #5 trn_clk = ~trn_clk;

   task automatic chk(input string name, input logic [65:0] got, input logic [65:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge trn_clk);
      #1;
   endtask

   // TX destination-ready pattern.
   initial begin
      trn_tdst_rdy_n = 1'b0;
      forever begin
         step();
         case (stall_mode)
            1:       trn_tdst_rdy_n = 1'($urandom_range(0, 1));
            2:       trn_tdst_rdy_n = ~trn_tdst_rdy_n;
            3:       trn_tdst_rdy_n = 1'b1;
            default: trn_tdst_rdy_n = 1'b0;
         endcase
      end
   end

   // Arbiter: grants grant_delay cycles after tx_req, holds until tx_req drops, resets with the DUT.
   initial begin
      int cnt;
      cnt = 0;
      tx_grant = 1'b0;
      forever begin
         @(negedge trn_clk);
         if (reset || !tx_req) begin
            tx_grant = 1'b0;
            cnt = 0;
         end else if (!tx_grant) begin
            if (cnt >= grant_delay) tx_grant = 1'b1;
            else cnt++;
         end
      end
   end

   // TX monitor: logs beats that the next edge accepts and checks stability under stalls.
   initial begin
      logic        have_prev;
      logic [65:0] prev;
      have_prev = 1'b0;
      prev = '0;
      forever begin
         @(negedge trn_clk);
         if (reset) begin
            have_prev = 1'b0;
         end else begin
            if (tx_req) req_cycles++;
            if (!trn_tsrc_rdy_n) begin
               total++;
               assert (tx_grant === 1'b1) else begin
                  bad++;
                  $error("FAIL grant_held: got %b want 1", tx_grant);
               end
               if (have_prev && ({trn_tsof_n, trn_teof_n, trn_td} !== prev)) stall_bad++;
               if (trn_trem_n !== 8'h00) stall_bad++;
               if (!trn_tdst_rdy_n) begin
                  acc_q.push_back({trn_tsof_n, trn_teof_n, trn_td});
                  have_prev = 1'b0;
               end else begin
                  stall_cycles++;
                  have_prev = 1'b1;
                  prev = {trn_tsof_n, trn_teof_n, trn_td};
               end
            end else begin
               have_prev = 1'b0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_reg(input logic [3:0] off);
      case (off)
         4'h8:    return sys_nsecs;
         4'h9:    return sys_secs;
         4'hA:    return {31'b0, rx_timestamp_en};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [65:0] exp_beat0(input logic [2:0] tc, input logic [1:0] attr);
      logic [63:0] b;
      b = (64'h4A << 56) | (64'(tc) << 52) | (64'(attr) << 44) | (64'd1 << 32)
        | (64'(cfg_completer_id) << 16) | 64'd4;
      return {1'b0, 1'b1, b};
   endfunction

   function automatic logic [65:0] exp_beat1(input logic [15:0] rid, input logic [7:0] tag,
                                             input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] sw;
      logic [63:0] b;
      sw = {<<8{data}};
      b = (64'(rid) << 48) | (64'(tag) << 40) | (64'(addr & 32'h7C) << 32) | 64'(sw);
      return {1'b1, 1'b0, b};
   endfunction

   // ---------------- RX stimulus ----------------
   task automatic send_rd(input bit is64, input bit bar0, input logic [31:0] addr,
                          input logic [15:0] rid, input logic [7:0] tag,
                          input logic [2:0] tc, input logic [1:0] attr);
      logic [31:0] dw0, dw1, hi;
      dw0 = {1'b0, (is64 ? 7'h20 : 7'h00), 1'b0, tc, 4'h0, 2'b00, attr, 2'b00, 10'd1};
      dw1 = {rid, tag, 8'h0F};
      hi  = $urandom;
      step();
      trn_rd = {dw0, dw1};
      trn_rsof_n = 1'b0;
      trn_reof_n = 1'b1;
      trn_rsrc_rdy_n = 1'b0;
      trn_rbar_hit_n = bar0 ? 7'h7E : 7'h7D;
      step();
      trn_rd = is64 ? {hi, addr} : {addr, 32'h0};
      trn_rsof_n = 1'b1;
      trn_reof_n = 1'b0;
      step();
      trn_rd = '0;
      trn_reof_n = 1'b1;
      trn_rsrc_rdy_n = 1'b1;
      trn_rbar_hit_n = 7'h7F;
   endtask

   task automatic wait_beats(input int want);
      int n;
      n = 0;
      while (acc_q.size() < want && n < 400) begin
         @(negedge trn_clk);
         n++;
      end
      repeat (4) @(negedge trn_clk);
   endtask

   task automatic do_read(input string tg, input bit is64, input bit bar0, input logic [31:0] addr,
                          input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                          input logic [1:0] attr, input bit lat, output logic [63:0] b1);
      bit          resp;
      logic [65:0] e0, e1;
      int          rc0;
      resp = bar0 && (addr[5:2] inside {4'h8, 4'h9, 4'hA});
      e0 = exp_beat0(tc, attr);
      e1 = exp_beat1(rid, tag, addr, model_reg(addr[5:2]));
      rc0 = req_cycles;
      b1 = '0;
      acc_q.delete();
      send_rd(is64, bar0, addr, rid, tag, tc, attr);
      if (resp) begin
         if (lat) begin
            chk({tg, " req_latency"}, 66'(tx_req), 66'd1);
            step();
            chk({tg, " sof_latency"}, 66'(trn_tsof_n), 66'd0);
         end
         wait_beats(2);
         chk({tg, " beat_count"}, 66'(acc_q.size()), 66'd2);
         if (acc_q.size() >= 2) begin
            chk({tg, " beat0"}, acc_q[0], e0);
            chk({tg, " beat1"}, acc_q[1], e1);
            b1 = acc_q[1][63:0];
         end
      end else begin
         repeat (30) @(negedge trn_clk);
         chk({tg, " no_req"}, 66'(req_cycles - rc0), 66'd0);
         chk({tg, " no_beats"}, 66'(acc_q.size()), 66'd0);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [63:0] b1;
      logic [65:0] e0, e1;
      int          s0, n;
      logic [3:0]  off;
      logic [31:0] addr;
      int          pick;

      reset = 1'b1;
      repeat (3) step();
      @(negedge trn_clk);
      chk("rst tx_req", 66'(tx_req), 66'd0);
      chk("rst tsof_n", 66'(trn_tsof_n), 66'd1);
      chk("rst teof_n", 66'(trn_teof_n), 66'd1);
      chk("rst tsrc_rdy_n", 66'(trn_tsrc_rdy_n), 66'd1);
      chk("rst td", 66'(trn_td), 66'd0);
      chk("rst trem_n", 66'(trn_trem_n), 66'hFF);
      chk("rst rd_overrun", 66'(rd_overrun), 66'd0);
      step();
      reset = 1'b0;
      step();

      // 1: MemRd32 nsecs, with request and SOF latency
      sys_nsecs = 32'h11223344;
      sys_secs = 32'hDEADBEEF;
      rx_timestamp_en = 1'b1;
      do_read("t1", 1'b0, 1'b1, 32'h20, 16'h0100, 8'h05, 3'd0, 2'd0, 1'b1, b1);
      chk("t1 literal beat1", 66'(b1), 66'h0100_0520_4433_2211);
      chk("t1 literal beat0", exp_beat0(3'd0, 2'd0), {2'b01, 32'h4A000001, cfg_completer_id, 16'h0004});

      // 2: MemRd64 secs
      do_read("t2", 1'b1, 1'b1, 32'h24, 16'h0203, 8'h11, 3'd5, 2'd2, 1'b0, b1);
      chk("t2 data", 66'(b1[31:0]), 66'hEFBEADDE);
      chk("t2 lower_addr", 66'(b1[39:32]), 66'h24);

      // 3: timestamp enable, then unmapped offset and BAR1
      do_read("t3", 1'b0, 1'b1, 32'h28, 16'h0304, 8'h22, 3'd1, 2'd1, 1'b0, b1);
      chk("t3 data", 66'(b1[31:0]), 66'h01000000);
      do_read("t3 off2c", 1'b0, 1'b1, 32'h2C, 16'h0304, 8'h23, 3'd0, 2'd0, 1'b0, b1);
      do_read("t3 bar1", 1'b0, 1'b0, 32'h20, 16'h0304, 8'h24, 3'd0, 2'd0, 1'b0, b1);

      // 4: delayed grant and toggling destination ready
      grant_delay = 10;
      stall_mode = 2;
      s0 = stall_cycles;
      stall_bad = 0;
      do_read("t4", 1'b0, 1'b1, 32'h20, 16'h0405, 8'h33, 3'd7, 2'd3, 1'b0, b1);
      chk("t4 stalls_seen", 66'(stall_cycles > s0), 66'd1);
      chk("t4 stable_under_stall", 66'(stall_bad), 66'd0);
      stall_mode = 0;

      // 5: second read while the first waits for grant
      grant_delay = 40;
      sys_nsecs = 32'hCAFE0001;
      e0 = exp_beat0(3'd2, 2'd1);
      e1 = exp_beat1(16'h0506, 8'h44, 32'h20, 32'hCAFE0001);
      acc_q.delete();
      send_rd(1'b0, 1'b1, 32'h20, 16'h0506, 8'h44, 3'd2, 2'd1);
      chk("t5 in_req", 66'(tx_req), 66'd1);
      sys_nsecs = 32'h0BADF00D;
      send_rd(1'b0, 1'b1, 32'h24, 16'h0607, 8'h55, 3'd0, 2'd0);
      @(negedge trn_clk);
      chk("t5 overrun_set", 66'(rd_overrun), 66'd1);
      wait_beats(2);
      repeat (30) @(negedge trn_clk);
      chk("t5 beat_count", 66'(acc_q.size()), 66'd2);
      if (acc_q.size() >= 2) begin
         chk("t5 beat0", acc_q[0], e0);
         chk("t5 beat1", acc_q[1], e1);
      end
      chk("t5 overrun_sticky", 66'(rd_overrun), 66'd1);

      // 6: reset while BEAT0 is stalled
      grant_delay = 0;
      stall_mode = 3;
      acc_q.delete();
      send_rd(1'b0, 1'b1, 32'h20, 16'h0708, 8'h66, 3'd0, 2'd0);
      n = 0;
      while (trn_tsof_n !== 1'b0 && n < 50) begin
         @(negedge trn_clk);
         n++;
      end
      chk("t6 reached_beat0", 66'(trn_tsof_n), 66'd0);
      step();
      reset = 1'b1;
      step();
      chk("t6 rst tx_req", 66'(tx_req), 66'd0);
      chk("t6 rst tsrc_rdy_n", 66'(trn_tsrc_rdy_n), 66'd1);
      chk("t6 rst tsof_n", 66'(trn_tsof_n), 66'd1);
      chk("t6 rst rd_overrun", 66'(rd_overrun), 66'd0);
      reset = 1'b0;
      stall_mode = 0;
      step();
      chk("t6 no_beats", 66'(acc_q.size()), 66'd0);
      sys_secs = 32'h01020304;
      do_read("t6 after", 1'b1, 1'b1, 32'h64, 16'h0809, 8'h77, 3'd3, 2'd0, 1'b0, b1);

      // randomized reads against the model
      for (int i = 0; i < 14; i++) begin
         sys_nsecs = $urandom;
         sys_secs = $urandom;
         rx_timestamp_en = 1'($urandom_range(0, 1));
         grant_delay = int'($urandom_range(0, 4));
         stall_mode = int'($urandom_range(0, 1));
         pick = int'($urandom_range(0, 5));
         off = (pick < 3) ? 4'(8 + pick) : 4'($urandom_range(0, 15));
         addr = $urandom;
         addr[5:2] = off;
         addr[1:0] = 2'b00;
         do_read($sformatf("rnd%0d", i), 1'($urandom), ($urandom_range(0, 7) != 0), addr,
                 16'($urandom), 8'($urandom), 3'($urandom), 2'($urandom), 1'b0, b1);
      end
      chk("rnd overrun_clear", 66'(rd_overrun), 66'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
